// File: rtl/fir_mac_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR MAC engine.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Accumulator width that can hold ORDER+1 full-scale products without overflow.
  function automatic int acc_w(input int sample_w, input int coef_w, input int order);
    return sample_w + coef_w + $clog2(order + 1);
  endfunction

  // Width of a tap index covering 0..order.
  function automatic int tap_idx_w(input int order);
    return (order < 1) ? 1 : $clog2(order + 1);
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  localparam int DEF_ORDER     = 4;
  localparam int DEF_SAMPLE_W  = 6;
  localparam int DEF_COEF_W    = 5;
  localparam int DEF_CHANNELS  = 2;
  localparam int DEF_TAP_IDX_W = tap_idx_w(DEF_ORDER);
  localparam int DEF_CH_IDX_W  = ch_idx_w(DEF_CHANNELS);

endpackage

// File: rtl/fir_tap_line.sv
// Per-channel sample history: ORDER+1 deep shift register with a tap read mux.
// taps[0] is the newest sample x[n], taps[k] is x[n-k].
module fir_tap_line
  import fir_mac_pkg::*;
#(
  parameter int ORDER    = DEF_ORDER,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  localparam int TAP_W   = tap_idx_w(ORDER)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [SAMPLE_W-1:0] din,
  input  logic [TAP_W-1:0]    rd_idx,
  output logic [SAMPLE_W-1:0] tap
);

  logic [SAMPLE_W-1:0] taps [ORDER+1];

  // Shift a new sample in at tap 0; the oldest sample falls off the end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= ORDER; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i <= ORDER; i++) taps[i] <= taps[i-1];
    end
  end

  // Select the tap currently being multiplied.
  always_comb begin
    tap = '0;
    for (int i = 0; i <= ORDER; i++) begin
      if (rd_idx == TAP_W'(i)) tap = taps[i];
    end
  end

endmodule

// File: rtl/fir_mac_tdm.sv
// Time-multiplexed multi-channel FIR MAC: one multiplier walks taps 0..ORDER
// serially for each accepted sample, with valid/ready on input and output.
// Optional build macro FIR_MAC_SAT_EN: saturate out_data to 2^OUT_W-1 instead
// of keeping the accumulator's low OUT_W bits.
module fir_mac_tdm
  import fir_mac_pkg::*;
#(
  parameter int ORDER    = DEF_ORDER,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int ACC_W    = acc_w(SAMPLE_W, COEF_W, ORDER),
  parameter int OUT_W    = ACC_W,
  localparam int TAP_W   = tap_idx_w(ORDER),
  localparam int CH_W    = ch_idx_w(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                coef_we,
  input  logic [TAP_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [OUT_W-1:0]    out_data,
  output logic                err
);

  localparam int PROD_W = SAMPLE_W + COEF_W;

  state_t               state;
  logic [TAP_W-1:0]     tap_idx;
  logic [CH_W-1:0]      cur_ch;
  logic [ACC_W-1:0]     acc;
  logic [COEF_W-1:0]    coef [ORDER+1];
  logic [SAMPLE_W-1:0]  tap_bus [CHANNELS];
  logic [SAMPLE_W-1:0]  tap_sel;
  logic [COEF_W-1:0]    coef_sel;
  logic [PROD_W-1:0]    prod;
  logic [ACC_W-1:0]     acc_sum;
  logic                 in_hs;
  logic                 ch_ok;
  logic                 coef_ok;
  logic                 last_tap;

  // Narrow the accumulator to the output width (saturate or wrap).
  function automatic logic [OUT_W-1:0] reduce_acc(input logic [ACC_W-1:0] a);
`ifdef FIR_MAC_SAT_EN
    logic [ACC_W-1:0] lim;
    lim = ACC_W'({OUT_W{1'b1}});
    if (a > lim) return '1;
    return a[OUT_W-1:0];
`else
    return a[OUT_W-1:0];
`endif
  endfunction

  assign in_ready = (state == IDLE);
  assign in_hs    = in_valid & in_ready;
  assign ch_ok    = ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));
  assign coef_ok  = (coef_addr <= TAP_W'(ORDER));
  assign last_tap = (tap_idx == TAP_W'(ORDER));

  // One history line per channel; only the addressed channel shifts on a handshake.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_line
    fir_tap_line #(
      .ORDER    (ORDER),
      .SAMPLE_W (SAMPLE_W)
    ) u_line (
      .clock    (clock),
      .reset    (reset),
      .shift_en (in_hs & ch_ok & (in_ch == CH_W'(c))),
      .din      (in_data),
      .rd_idx   (tap_idx),
      .tap      (tap_bus[c])
    );
  end

  // Route the active channel's tap and the matching coefficient to the multiplier.
  always_comb begin
    tap_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cur_ch == CH_W'(c)) tap_sel = tap_bus[c];
    end
    coef_sel = '0;
    for (int k = 0; k <= ORDER; k++) begin
      if (tap_idx == TAP_W'(k)) coef_sel = coef[k];
    end
  end

  assign prod    = {{COEF_W{1'b0}}, tap_sel} * {{SAMPLE_W{1'b0}}, coef_sel};
  assign acc_sum = acc + ACC_W'(prod);

  // Coefficient bank: writes land only while idle, so a write in the handshake
  // cycle is already visible to the first MAC cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= ORDER; k++) coef[k] <= '0;
    end else if (state == IDLE && coef_we && coef_ok) begin
      for (int k = 0; k <= ORDER; k++) begin
        if (coef_addr == TAP_W'(k)) coef[k] <= coef_data;
      end
    end
  end

  // Control FSM with accumulator and registered output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tap_idx   <= '0;
      cur_ch    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (ch_ok) begin
              cur_ch  <= in_ch;
              acc     <= '0;
              tap_idx <= '0;
              state   <= MAC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (last_tap) begin
            out_data  <= reduce_acc(acc_sum);
            out_ch    <= cur_ch;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            tap_idx <= tap_idx + TAP_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (coef_we && state != IDLE) err <= 1'b1;
    end
  end

endmodule

// File: doc/fir_mac_tdm.md
# fir_mac_tdm

Time-multiplexed, multi-channel FIR multiply-accumulate engine that generalises the fixed-order pipelined FIR MAC. It is parametrised in order, widths and channel count, has run-time loadable coefficients, and uses valid/ready handshakes on input and output. A single multiplier is reused serially across all taps. The block sits between the sample source and downstream filter consumers in the FIR_MAC subsystem.

## Interface
- ORDER, 4, filter order; there are ORDER+1 taps.
- SAMPLE_W, 6, width of an unsigned sample.
- COEF_W, 5, width of an unsigned coefficient.
- CHANNELS, 2, number of independent sample channels that share one coefficient set; must be ≥1.
- ACC_W, SAMPLE_W+COEF_W+$clog2(ORDER+1), accumulator width; the accumulator never overflows.
- OUT_W, ACC_W, output width; must be ≤ACC_W.
- clock  in  1  single clock; all logic updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a sample is offered.
- in_ready  out  1  the block can accept a sample; high only in IDLE.
- in_ch  in  max(1,$clog2(CHANNELS))  channel of the offered sample.
- in_data  in  SAMPLE_W  sample value.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(ORDER+1)  tap index to write.
- coef_data  in  COEF_W  coefficient value.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer accepts the result.
- out_ch  out  max(1,$clog2(CHANNELS))  channel of the result.
- out_data  out  OUT_W  filter result.
- err  out  1  one-cycle pulse for a dropped coefficient write or an out-of-range channel.

## Operation
- Per channel c: y_c[n] = Σ_{k=0..ORDER} coef[k]·x_c[n−k], computed on unsigned values. The delay-line history of each channel is independent.
- FSM states and transitions:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) shifts in_data into the tap line of in_ch (the oldest sample is discarded), latches the channel, clears the accumulator, and moves to MAC.
  - MAC: processes one tap per cycle, k=0..ORDER, adding coef[k]·tap[k] to the accumulator. After tap ORDER the FSM moves to DONE.
  - DONE: out_valid=1 and out_data/out_ch are held stable. On out_ready the FSM returns to IDLE.
- Out-of-range channel (in_ch ≥ CHANNELS): the handshake completes, the sample is discarded, err pulses, and the FSM stays in IDLE.
- Coefficient writes take effect in IDLE only. A write in the same cycle as an input handshake is applied before the first MAC cycle, so the new value is used. A write in MAC or DONE is dropped, err pulses, and the coefficient is unchanged.
- Output width reduction (OUT_W<ACC_W) follows the rule under Configuration.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_ch=0, err=0. All tap lines and all coefficients are cleared to 0.
- Latency: a handshake at edge t gives MAC cycles t+1..t+ORDER+1 and out_valid high from t+ORDER+2.
- Throughput: with out_ready held high, one sample per ORDER+3 cycles.
- out_valid/out_data may only change after a completed output handshake or on reset.
- in_ready is a registered-state decode with no combinational path from out_ready.
- Reset asserted mid-MAC or mid-DONE: the partial result is discarded and no out_valid is produced after reset.

## Configuration
- FIR_MAC_SAT_EN defined: when the accumulator exceeds 2^OUT_W−1, out_data saturates to 2^OUT_W−1.
- FIR_MAC_SAT_EN undefined: out_data is the accumulator's low OUT_W bits (wrap).
- When OUT_W==ACC_W both builds behave identically.

## Structure
- Package fir_mac_pkg holds:
  - the FSM state enum (IDLE, MAC, DONE);
  - the ACC_W width helper function;
  - the tap-index and channel-index width constants.
- Sub-module fir_tap_line: one per channel, generated CHANNELS times. It is an ORDER+1 deep shift register with a shift enable and a tap read mux.
- The top level owns the FSM, coefficient bank, multiplier, accumulator and output register.

## Test plan
All scenarios use ORDER=4, SAMPLE_W=6, COEF_W=5, CHANNELS=2 and coefficients 1,2,3,4,5.
- Impulse response: ch0 samples 1,0,0,0,0,0 → out_data 1,2,3,4,5,0, with out_valid exactly 6 cycles after each handshake.
- Channel isolation: interleave ch1 sample 10 after the ch0 impulse → ch1 result 10; subsequent ch0 results are unchanged.
- Full scale: all coefficients 31, ch0 samples 63×5 → final result 9765 (OUT_W=14). With OUT_W=12, the result is 4095 under FIR_MAC_SAT_EN and 1573 without it.
- Backpressure: out_ready low for 5 cycles in DONE → out_data and out_valid hold, in_ready stays 0, and no sample is accepted.
- Coefficient hazards:
  - write coef[0]=7 during MAC → err pulse and the result is unchanged;
  - the same write in the handshake cycle → the result uses 7.
- Reset mid-MAC: assert reset 2 cycles after a handshake → all outputs return to their reset values and the next impulse gives result 0 with all-zero coefficients.
